// File: rtl/sparsity_encoder_pkg.sv
// Shared constants, FSM state encoding and the row-of-index helper used by the
// sparsity encoder and anyone rebuilding its per-row counts.
package sparsity_encoder_pkg;

    localparam int IF_WIDTH     = 16;
    localparam int IF_SIZE      = 4;
    localparam int KERNEL_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } enc_state_e;

    // Kernel row that a flattened element index falls into (0, 1 or 2).
    function automatic logic [1:0] row_of(input int unsigned idx, input int unsigned kw);
        if (idx < kw) begin
            return 2'd0;
        end else if (idx < 2 * kw) begin
            return 2'd1;
        end
        return 2'd2;
    endfunction

endpackage

// File: rtl/sparsity_row_counter.sv
// Three saturating per-kernel-row nonzero counters; row_cnt_o already
// includes the pulse of the current cycle so a caller can latch it on that edge.
module sparsity_row_counter
    import sparsity_encoder_pkg::*;
#(
    parameter int IDX_WIDTH     = 4,
    parameter int ROW_CNT_WIDTH = 2,
    parameter int KW            = KERNEL_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_i,
    input  logic                       flag_pulse_i,
    input  logic [IDX_WIDTH-1:0]       elem_idx_i,
    output logic [3*ROW_CNT_WIDTH-1:0] row_cnt_o
);

    localparam logic [ROW_CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [ROW_CNT_WIDTH-1:0] cnt_q [3];
    logic [ROW_CNT_WIDTH-1:0] cnt_d [3];
    logic [1:0]               row;

    always_comb begin
        row = row_of(32'(elem_idx_i), KW);
        for (int r = 0; r < 3; r++) begin
            cnt_d[r] = cnt_q[r];
            if (flag_pulse_i && (row == 2'(r)) && (cnt_q[r] != CNT_MAX)) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end
        end
    end

    assign row_cnt_o = {cnt_d[2], cnt_d[1], cnt_d[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                cnt_q[r] <= '0;
            end
        end else if (clear_i) begin
            for (int r = 0; r < 3; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < 3; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule

// File: rtl/sparsity_encoder.sv
// Producer side of the sparsity-flag RAM: writes one flag per dense element,
// compacts nonzero values into the value RAM and reports per-frame counts.
module sparsity_encoder
    import sparsity_encoder_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = IF_SIZE,
    parameter int FRAME_LEN     = IF_WIDTH,
    parameter int KW            = KERNEL_WIDTH,
    parameter int ROW_CNT_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mode,
    input  logic                       start,
    output logic                       busy,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       flag_wr_req,
    output logic                       flag_wr_data,
    output logic [ADDR_WIDTH-1:0]      flag_wr_addr,
    output logic                       val_wr_req,
    output logic [DATA_WIDTH-1:0]      val_wr_data,
    output logic [ADDR_WIDTH-1:0]      val_wr_addr,
    output logic [ADDR_WIDTH:0]        nnz_count,
    output logic [3*ROW_CNT_WIDTH-1:0] row_nnz,
    output logic                       done
);

    enc_state_e                 state_q;
    logic                       mode_q;
    logic                       busy_q;
    logic [ADDR_WIDTH-1:0]      last_idx_q;
    logic [ADDR_WIDTH-1:0]      elem_idx_q;
    logic [ADDR_WIDTH:0]        nz_idx_q;
    logic                       flag_req_q;
    logic                       flag_data_q;
    logic [ADDR_WIDTH-1:0]      flag_addr_q;
    logic                       val_req_q;
    logic [DATA_WIDTH-1:0]      val_data_q;
    logic [ADDR_WIDTH-1:0]      val_addr_q;
    logic [ADDR_WIDTH:0]        nnz_q;
    logic [3*ROW_CNT_WIDTH-1:0] row_nnz_q;
    logic                       done_q;

    logic                       accept;
    logic                       elem_nz;
    logic [ADDR_WIDTH:0]        nz_idx_d;
    logic                       row_pulse;
    logic                       row_clear;
    logic [3*ROW_CNT_WIDTH-1:0] row_cnt;

    always_comb begin
        accept    = (state_q == RUN) && in_valid;
        elem_nz   = |in_data;
        nz_idx_d  = nz_idx_q + (ADDR_WIDTH+1)'(elem_nz);
        row_pulse = accept && elem_nz && mode_q;
        row_clear = (state_q == IDLE) && start;
    end

    sparsity_row_counter #(
        .IDX_WIDTH     (ADDR_WIDTH),
        .ROW_CNT_WIDTH (ROW_CNT_WIDTH),
        .KW            (KW)
    ) u_row_counter (
        .clk          (clk),
        .rst_n        (reset),
        .clear_i      (row_clear),
        .flag_pulse_i (row_pulse),
        .elem_idx_i   (elem_idx_q),
        .row_cnt_o    (row_cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            last_idx_q  <= '0;
            elem_idx_q  <= '0;
            nz_idx_q    <= '0;
            flag_req_q  <= 1'b0;
            flag_data_q <= 1'b0;
            flag_addr_q <= '0;
            val_req_q   <= 1'b0;
            val_data_q  <= '0;
            val_addr_q  <= '0;
            nnz_q       <= '0;
            row_nnz_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            // Write strobes are single-cycle; idle write buses are driven to 0.
            flag_req_q  <= 1'b0;
            flag_data_q <= 1'b0;
            flag_addr_q <= '0;
            val_req_q   <= 1'b0;
            val_data_q  <= '0;
            val_addr_q  <= '0;
            done_q      <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RUN;
                        busy_q     <= 1'b1;
                        mode_q     <= mode;
                        last_idx_q <= mode ? ADDR_WIDTH'(KW * KW - 1) : ADDR_WIDTH'(FRAME_LEN - 1);
                        elem_idx_q <= '0;
                        nz_idx_q   <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        flag_req_q  <= 1'b1;
                        flag_data_q <= elem_nz;
                        flag_addr_q <= elem_idx_q;
                        if (elem_nz) begin
                            val_req_q  <= 1'b1;
                            val_data_q <= in_data;
                            val_addr_q <= nz_idx_q[ADDR_WIDTH-1:0];
                        end
                        nz_idx_q <= nz_idx_d;
                        if (elem_idx_q == last_idx_q) begin
                            // Counts are published on the same edge as the last write.
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            nnz_q      <= nz_idx_d;
                            row_nnz_q  <= mode_q ? row_cnt : '0;
                            elem_idx_q <= '0;
                        end else begin
                            elem_idx_q <= elem_idx_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign in_ready     = (state_q == RUN);
    assign flag_wr_req  = flag_req_q;
    assign flag_wr_data = flag_data_q;
    assign flag_wr_addr = flag_addr_q;
    assign val_wr_req   = val_req_q;
    assign val_wr_data  = val_data_q;
    assign val_wr_addr  = val_addr_q;
    assign nnz_count    = nnz_q;
    assign row_nnz      = row_nnz_q;
    assign done         = done_q;

endmodule

// File: tb/tb_sparsity_encoder.sv
// Directed bench for sparsity_encoder: frames of known content, write logs
// captured on the falling edge and compared against hand-derived values.
module tb_sparsity_encoder;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int RCW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              mode;
    logic              start;
    logic              busy;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              flag_wr_req;
    logic              flag_wr_data;
    logic [AW-1:0]     flag_wr_addr;
    logic              val_wr_req;
    logic [DW-1:0]     val_wr_data;
    logic [AW-1:0]     val_wr_addr;
    logic [AW:0]       nnz_count;
    logic [3*RCW-1:0]  row_nnz;
    logic              done;

    sparsity_encoder dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .start        (start),
        .busy         (busy),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .flag_wr_req  (flag_wr_req),
        .flag_wr_data (flag_wr_data),
        .flag_wr_addr (flag_wr_addr),
        .val_wr_req   (val_wr_req),
        .val_wr_data  (val_wr_data),
        .val_wr_addr  (val_wr_addr),
        .nnz_count    (nnz_count),
        .row_nnz      (row_nnz),
        .done         (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // Write log, appended on every falling edge.
    int            fl_n = 0;
    int            vl_n = 0;
    int            done_n = 0;
    logic [AW-1:0] fl_addr [256];
    logic          fl_data [256];
    logic [AW-1:0] vl_addr [256];
    logic [DW-1:0] vl_data [256];

    always @(negedge clk) begin
        if (flag_wr_req && fl_n < 256) begin
            fl_addr[fl_n] <= flag_wr_addr;
            fl_data[fl_n] <= flag_wr_data;
            fl_n          <= fl_n + 1;
        end
        if (val_wr_req && vl_n < 256) begin
            vl_addr[vl_n] <= val_wr_addr;
            vl_data[vl_n] <= val_wr_data;
            vl_n          <= vl_n + 1;
        end
        if (done) begin
            done_n <= done_n + 1;
        end
    end

    logic [DW-1:0] vec [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic m, input int n, input bit stall, input bit poke,
                             input logic [31:0] exp_nnz, input logic [31:0] exp_row);
        int            fb;
        int            vb;
        int            db;
        int            nz;
        logic [DW-1:0] nzv [16];
        fb = fl_n;
        vb = vl_n;
        db = done_n;
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("busy_after_start", 32'(busy), 32'd1);
        check_eq("ready_after_start", 32'(in_ready), 32'd1);
        for (int i = 0; i < n; i++) begin
            if (stall) begin
                in_valid = 1'b0;
                in_data  = '0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = vec[i];
            if (poke && i == 1) mode = ~m;
            if (poke && i == 2) start = 1'b1;
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
        in_data  = '0;
        // One cycle after the last accept: the DONE cycle.
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("busy_in_done", 32'(busy), 32'd1);
        check_eq("ready_in_done", 32'(in_ready), 32'd0);
        check_eq("nnz_count", 32'(nnz_count), exp_nnz);
        check_eq("row_nnz", 32'(row_nnz), exp_row);
        if (poke) start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("busy_after_done", 32'(busy), 32'd0);
        check_eq("done_single", 32'(done), 32'd0);
        tick();
        check_eq("busy_stays_idle", 32'(busy), 32'd0);
        check_eq("nnz_hold", 32'(nnz_count), exp_nnz);
        check_eq("row_hold", 32'(row_nnz), exp_row);
        check_eq("done_count", 32'(done_n - db), 32'd1);
        check_eq("flag_writes", 32'(fl_n - fb), 32'(n));
        nz = 0;
        for (int i = 0; i < n; i++) begin
            check_eq("flag_addr", 32'(fl_addr[fb + i]), 32'(i));
            check_eq("flag_data", 32'(fl_data[fb + i]), 32'(vec[i] != 0));
            if (vec[i] != 0) begin
                nzv[nz] = vec[i];
                nz++;
            end
        end
        check_eq("val_writes", 32'(vl_n - vb), 32'(nz));
        for (int j = 0; j < nz; j++) begin
            check_eq("val_addr", 32'(vl_addr[vb + j]), 32'(j));
            check_eq("val_data", 32'(vl_data[vb + j]), 32'(nzv[j]));
        end
    endtask

    initial begin
        int db;
        int vb;
        reset    = 1'b0;
        mode     = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd0);
        check_eq("rst_flag_req", 32'(flag_wr_req), 32'd0);
        check_eq("rst_nnz", 32'(nnz_count), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        tick();

        // Weight frame [0,5,0, 7,7,0, 0,0,1]: nnz 4, rows {1,2,1}.
        vec[0] = 8'd0; vec[1] = 8'd5; vec[2] = 8'd0;
        vec[3] = 8'd7; vec[4] = 8'd7; vec[5] = 8'd0;
        vec[6] = 8'd0; vec[7] = 8'd0; vec[8] = 8'd1;
        vb = vl_n;
        run_frame(1'b1, 9, 1'b0, 1'b0, 32'd4, 32'h19);
        check_eq("w_val0", 32'(vl_data[vb + 0]), 32'd5);
        check_eq("w_val1", 32'(vl_data[vb + 1]), 32'd7);
        check_eq("w_val2", 32'(vl_data[vb + 2]), 32'd7);
        check_eq("w_val3", 32'(vl_data[vb + 3]), 32'd1);

        // Back-to-back all-zero activation frame: row counts replaced by 0.
        for (int i = 0; i < 16; i++) vec[i] = 8'h00;
        run_frame(1'b0, 16, 1'b0, 1'b0, 32'd0, 32'd0);

        // All-0xFF frame with stalls, start pokes and a mid-frame mode flip.
        for (int i = 0; i < 16; i++) vec[i] = 8'hFF;
        run_frame(1'b0, 16, 1'b1, 1'b1, 32'd16, 32'd0);

        // Reset after element 4 of an activation frame.
        for (int i = 0; i < 16; i++) vec[i] = 8'h11;
        db    = done_n;
        mode  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = vec[i];
            tick();
        end
        check_eq("pre_rst_flag_req", 32'(flag_wr_req), 32'd1);
        check_eq("pre_rst_flag_addr", 32'(flag_wr_addr), 32'd4);
        reset = 1'b0;
        #1;
        check_eq("midrst_flag_req", 32'(flag_wr_req), 32'd0);
        check_eq("midrst_flag_addr", 32'(flag_wr_addr), 32'd0);
        check_eq("midrst_val_req", 32'(val_wr_req), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_ready", 32'(in_ready), 32'd0);
        check_eq("midrst_nnz", 32'(nnz_count), 32'd0);
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        check_eq("midrst_no_done", 32'(done_n - db), 32'd0);

        // Post-reset activation frame: odd elements nonzero, nnz 8.
        for (int i = 0; i < 16; i++) vec[i] = (i % 2 == 1) ? 8'(i) : 8'h00;
        run_frame(1'b0, 16, 1'b0, 1'b0, 32'd8, 32'd0);

        // All-nonzero weight frame: every row saturates at 3.
        for (int i = 0; i < 9; i++) vec[i] = 8'(i + 1);
        run_frame(1'b1, 9, 1'b0, 1'b0, 32'd9, 32'h3F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sparsity_encoder.md
Name: sparsity_encoder

Overview:
- Producer side of the serial sparsity-flag RAM.
- Consumes a dense activation or weight stream, one element per handshake.
- Per element, writes a 1-bit nonzero flag into the flag RAM at a sequential address. Writes nonzero values only into a compacted value RAM.
- Reports per-frame nonzero totals and, in weight mode, per-kernel-row counts. These match the counts the flag reader reconstructs downstream.

Parameters:
- DATA_WIDTH, 8, element width.
- ADDR_WIDTH, 4, flag/value RAM address width (equals IF_SIZE).
- FRAME_LEN, 16, elements per activation frame in mode 0 (equals IF_WIDTH); must satisfy FRAME_LEN <= 2^ADDR_WIDTH.
- KERNEL_WIDTH, 3, kernel side; mode-1 frame length is KERNEL_WIDTH*KERNEL_WIDTH = 9.
- ROW_CNT_WIDTH, 2, width of each per-row count.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mode  in  1  1 = weight frame (9 elements), 0 = activation frame (FRAME_LEN elements); sampled on accepted start.
- start  in  1  one-cycle request to begin a frame; accepted only in IDLE.
- busy  out  1  high from accepted start until done.
- in_valid  in  1  element valid.
- in_ready  out  1  high only in RUN.
- in_data  in  DATA_WIDTH  dense element.
- flag_wr_req  out  1  flag RAM write strobe.
- flag_wr_data  out  1  1 if element != 0.
- flag_wr_addr  out  ADDR_WIDTH  element index within frame.
- val_wr_req  out  1  value RAM write strobe (nonzero elements only).
- val_wr_data  out  DATA_WIDTH  nonzero element.
- val_wr_addr  out  ADDR_WIDTH  compacted index.
- nnz_count  out  ADDR_WIDTH+1  nonzero count of last completed frame.
- row_nnz  out  3*ROW_CNT_WIDTH  {row2,row1,row0} nonzero counts of last weight frame; zero after an activation frame.
- done  out  1  one-cycle pulse when the frame's last write has been issued.

Behaviour:
- Reset (asynchronous, reset == 0):
  - All outputs 0; state IDLE; all counters 0.
  - Reset mid-frame abandons the frame; no done pulse.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start. Latches mode and sets frame_len to 9 or FRAME_LEN. Clears elem_idx, nz_idx, row accumulators.
  - start while busy is ignored.
- RUN:
  - in_ready = 1. An element is accepted on in_valid && in_ready.
  - Accepted element produces, on the next cycle (1-cycle registered latency):
    - flag_wr_req = 1, flag_wr_addr = elem_idx, flag_wr_data = (in_data != 0).
    - If nonzero: val_wr_req = 1, val_wr_addr = nz_idx, val_wr_data = in_data; nz_idx then increments.
    - elem_idx increments every accept.
  - in_valid low stalls with no writes; there is no timeout.
  - Accept of element frame_len-1 moves to DONE. in_ready drops the same edge, so no extra element is accepted.
- DONE (one cycle):
  - Last write strobes are visible this cycle.
  - done = 1; nnz_count = final nz_idx; row_nnz updated; busy remains 1.
  - Next state IDLE; busy = 0.
- Row counts (mode 1 only):
  - Elements 0-2 count into row0, 3-5 into row1, 6-8 into row2.
  - Each count saturates naturally at 3; counts are added before the done edge.
  - Mode 0: row_nnz = 0.
- Widths:
  - nnz_count holds 0..FRAME_LEN, hence ADDR_WIDTH+1 bits.
  - Address counters never wrap within a frame and restart at 0 each frame.
- Hold rules:
  - nnz_count and row_nnz hold until the next done.
  - Write strobes are single-cycle per element; data/addr are don't-care when the strobe is low, but are driven 0.
- Boundaries:
  - All-zero frame: 0 value writes, nnz_count = 0.
  - All-nonzero frame: nnz_count = frame_len, val_wr_addr reaches frame_len-1.
  - start asserted in the DONE cycle is ignored; it is accepted from IDLE one cycle later.
  - mode changes mid-frame have no effect.

Decomposition:
- Shared package/header (existing defines):
  - IF_WIDTH, IF_SIZE, KERNEL_WIDTH.
  - State encoding localparams IDLE/RUN/DONE.
- Sub-module: sparsity_row_counter.
  - Takes an element-index and flag pulse; produces three saturating row counts.
  - Reused by reader-side checking.
- The rest is a single always-block FSM plus a write-stage register.

Test Plan:
- Mode 1, weights [0,5,0, 7,7,0, 0,0,1]:
  - 9 flag writes, addr 0..8, bits 010110001.
  - 4 value writes {5,7,7,1} at addr 0..3.
  - nnz_count = 4, row_nnz = {1,2,1}, done one cycle after last accept.
- Mode 0, 16 elements all zero -> 16 flag writes of 0, no val_wr_req, nnz_count = 0, row_nnz = 0.
- Mode 0, 16 elements all 0xFF with in_valid toggling every other cycle:
  - 16 value writes, addr 0..15, no writes during stall cycles.
  - nnz_count = 16.
- start pulsed during RUN and during DONE -> ignored; only one done per accepted frame; busy low for at least one cycle between frames.
- reset asserted after element 4 of a mode-0 frame:
  - Outputs 0 immediately, no done.
  - Next frame starts at flag_wr_addr 0, val_wr_addr 0.
- Back-to-back mode 1 then mode 0 frames -> row_nnz is replaced by 0 at the second done; nnz_count reflects only the second frame.
